// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, op type, legality check and the
// response-slot state encoding used by the ALU arbiter.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_AND = 4'b0000;
  localparam alu_op_t ALU_OR  = 4'b0001;
  localparam alu_op_t ALU_ADD = 4'b0010;
  localparam alu_op_t ALU_SUB = 4'b0110;

  // Response register occupancy
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // True for the four control codes the ALU actually implements
  function automatic logic is_legal_op(input alu_op_t op);
    logic legal;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Requester selection for the ALU arbiter.
// Default build: round-robin starting at rr_ptr, pointer moves past the
// winner only when the grant is actually consumed (advance).
// With ALU_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins,
// and no pointer state exists.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_any
);

`ifdef ALU_ARB_FIXED_PRIO_EN

  logic unused_seq;
  assign unused_seq = ^{clk, reset, advance};

  // Lowest-index valid requester wins; scan downward so the last hit is the lowest
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(i);
      end
    end
  end

`else

  logic [IDW-1:0] rr_ptr;

  // First valid requester at or after rr_ptr, wrapping; scan from the far end so the nearest hit sticks
  always_comb begin
    int cand;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (req[cand[IDW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[IDW-1:0];
      end
    end
  end

  // Pointer moves just past the winner on a consumed grant, wrapping NREQ-1 -> 0
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (advance) begin
      if (grant_idx == IDW'(NREQ - 1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= grant_idx + IDW'(1);
      end
    end
  end

`endif

  // Expand the winning index into a one-hot grant vector
  always_comb begin
    grant = '0;
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters. The winner's op and
// operands drive the ALU; on a handshake the ALU result is captured into a
// single-entry response register with its own valid/ready handshake.
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed priority instead of
// round-robin (handled inside rr_arbiter).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2,
  parameter int IDW   = ($clog2(NREQ) < 1) ? 1 : $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [4*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic [3:0]            alu_ctrl,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  input  logic [WIDTH-1:0]      alu_out,
  input  logic                  alu_zero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_zero,
  output logic                  rsp_err
);

  slot_state_t     slot;
  logic            can_accept;
  logic            transfer;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .advance   (transfer),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // The slot can take a new result if it is empty or is being drained this cycle
  assign can_accept = (slot == SLOT_EMPTY) || rsp_ready;
  assign rsp_valid  = (slot == SLOT_FULL);

  // Accept only the winner, only when the slot has room, and never while in reset
  always_comb begin
    req_ready = '0;
    if (grant_any && can_accept && !reset) begin
      req_ready = grant;
    end
  end

  assign transfer = |req_ready;

  // Winner drives the ALU even when stalled; idle drive is ADD 0+0
  always_comb begin
    alu_ctrl = ALU_ADD;
    alu_a    = '0;
    alu_b    = '0;
    if (grant_any) begin
      alu_ctrl = req_op[int'(grant_idx)*4 +: 4];
      alu_a    = req_a[int'(grant_idx)*WIDTH +: WIDTH];
      alu_b    = req_b[int'(grant_idx)*WIDTH +: WIDTH];
    end
  end

  // Response slot: capture the ALU result on transfer, empty on drain, data held otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      slot     <= SLOT_EMPTY;
      rsp_id   <= '0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      if (transfer) begin
        rsp_id   <= grant_idx;
        rsp_data <= alu_out;
        rsp_zero <= alu_zero;
        rsp_err  <= !is_legal_op(alu_ctrl);
      end
      case (slot)
        SLOT_EMPTY: begin
          if (transfer) begin
            slot <= SLOT_FULL;
          end
        end
        SLOT_FULL: begin
          if (!transfer && rsp_ready) begin
            slot <= SLOT_EMPTY;
          end
        end
        default: slot <= SLOT_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a stand-in ALU, a behavioural model
// of the arbiter checked every cycle, directed scenarios with literal
// expectations, then a randomized phase. Honours ALU_ARB_FIXED_PRIO_EN.
module tb_alu_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 2;
  localparam int IDW   = 1;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [4*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic [3:0]            alu_ctrl;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [WIDTH-1:0]      alu_out;
  logic                  alu_zero;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_zero;
  logic                  rsp_err;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_ctrl  (alu_ctrl),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // What the ALU computes for a control code; unknown codes give all ones
  function automatic logic [WIDTH-1:0] aluModel(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (op)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      default: return '1;
    endcase
  endfunction

  function automatic bit isLegal(input logic [3:0] op);
    return (op == 4'b0010) || (op == 4'b0110) || (op == 4'b0000) || (op == 4'b0001);
  endfunction

  // Stand-in for the ALU instance the parent would provide
  always_comb begin
    alu_out  = aluModel(alu_ctrl, alu_a, alu_b);
    alu_zero = (alu_out == '0);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic v, input logic [3:0] op,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_valid[idx]              = v;
    req_op[idx*4 +: 4]          = op;
    req_a[idx*WIDTH +: WIDTH]   = a;
    req_b[idx*WIDTH +: WIDTH]   = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model state
  bit               live = 1'b0;
  int               mPtr;
  bit               mValid;
  int               mId;
  logic [WIDTH-1:0] mData;
  bit               mZero;
  bit               mErr;
  logic [NREQ-1:0]  lastReady = '0;

  // Every cycle: predict the outputs from the rules, compare, then advance the model
  always @(negedge clk) begin
    int               w;
    int               c;
    bit               found;
    logic [NREQ-1:0]  expReady;
    logic [3:0]       expCtrl;
    logic [WIDTH-1:0] expA;
    logic [WIDTH-1:0] expB;
    found = 1'b0;
    w     = 0;
    for (int k = 0; k < NREQ; k++) begin
      c = FIXED ? k : (mPtr + k) % NREQ;
      if (!found && req_valid[c]) begin
        found = 1'b1;
        w     = c;
      end
    end
    expReady = '0;
    if (found && (!mValid || rsp_ready) && !reset) expReady[w] = 1'b1;
    expCtrl = 4'b0010;
    expA    = '0;
    expB    = '0;
    if (found) begin
      expCtrl = req_op[w*4 +: 4];
      expA    = req_a[w*WIDTH +: WIDTH];
      expB    = req_b[w*WIDTH +: WIDTH];
    end
    if (live) begin
      checkOutput("model req_ready", 32'(req_ready), 32'(expReady));
      checkOutput("model alu_ctrl", 32'(alu_ctrl), 32'(expCtrl));
      checkOutput("model alu_a", alu_a, expA);
      checkOutput("model alu_b", alu_b, expB);
      checkOutput("model rsp_valid", 32'(rsp_valid), 32'(mValid));
      checkOutput("model rsp_id", 32'(rsp_id), 32'(mId));
      checkOutput("model rsp_data", rsp_data, mData);
      checkOutput("model rsp_zero", 32'(rsp_zero), 32'(mZero));
      checkOutput("model rsp_err", 32'(rsp_err), 32'(mErr));
    end
    if (reset) begin
      live   = 1'b1;
      mPtr   = 0;
      mValid = 1'b0;
      mId    = 0;
      mData  = '0;
      mZero  = 1'b0;
      mErr   = 1'b0;
    end else if (expReady != '0) begin
      mValid = 1'b1;
      mId    = w;
      mData  = aluModel(expCtrl, expA, expB);
      mZero  = (mData == '0);
      mErr   = !isLegal(expCtrl);
      mPtr   = (w + 1) % NREQ;
    end else if (rsp_ready) begin
      mValid = 1'b0;
    end
    lastReady = expReady;
  end

  initial begin
    logic [3:0] op;
    int         sel;
    reset     = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    @(posedge clk);
    @(negedge clk);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset rsp_data", rsp_data, 32'd0);
    checkOutput("reset rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("reset req_ready", 32'(req_ready), 32'd0);

    // Single ADD
    tick();
    reset = 1'b0;
    applyStimulus(0, 1'b1, 4'b0010, 32'd5, 32'd7);
    @(negedge clk);
    checkOutput("add req_ready", 32'(req_ready), 32'h1);
    checkOutput("add alu_a", alu_a, 32'd5);
    tick();
    applyStimulus(0, 1'b0, 4'b0000, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("add rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("add rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("add rsp_data", rsp_data, 32'd12);
    checkOutput("add rsp_zero", 32'(rsp_zero), 32'd0);
    checkOutput("add rsp_err", 32'(rsp_err), 32'd0);

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 0 always wins
    tick();
    applyStimulus(0, 1'b1, 4'b0110, 32'd9, 32'd9);
    applyStimulus(1, 1'b1, 4'b0001, 32'hF0, 32'h0F);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) begin
        checkOutput("fixed req_ready1", 32'(req_ready[1]), 32'd0);
        checkOutput("fixed req_ready", 32'(req_ready), 32'h1);
      end
      if (i > 0) checkOutput("fixed rsp_id", 32'(rsp_id), 32'd0);
      tick();
    end
`else
    // Pointer back to 0 before contention
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Contention: alternate 0,1,0,1
    applyStimulus(0, 1'b1, 4'b0110, 32'd9, 32'd9);
    applyStimulus(1, 1'b1, 4'b0001, 32'hF0, 32'h0F);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rr req_ready", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      if (i > 0) begin
        checkOutput("rr rsp_id", 32'(rsp_id), 32'((i - 1) % 2));
        checkOutput("rr rsp_data", rsp_data, ((i - 1) % 2 == 0) ? 32'h0 : 32'hFF);
        checkOutput("rr rsp_zero", 32'(rsp_zero), ((i - 1) % 2 == 0) ? 32'd1 : 32'd0);
      end
      tick();
    end
    applyStimulus(1, 1'b0, 4'b0000, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("rr last rsp_id", 32'(rsp_id), 32'd1);
    checkOutput("rr last rsp_data", rsp_data, 32'hFF);
    checkOutput("rr last req_ready", 32'(req_ready), 32'h1);
    tick();

    // Backpressure with response FULL (SUB 9-9 from req0)
    applyStimulus(0, 1'b0, 4'b0000, 32'd0, 32'd0);
    applyStimulus(1, 1'b1, 4'b0000, 32'hFFFF0000, 32'h12345678);
    rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("bp req_ready", 32'(req_ready), 32'd0);
      checkOutput("bp rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp rsp_id", 32'(rsp_id), 32'd0);
      checkOutput("bp rsp_zero", 32'(rsp_zero), 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp release req_ready", 32'(req_ready), 32'h2);
    tick();
    applyStimulus(1, 1'b0, 4'b0000, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("bp rsp_data", rsp_data, 32'h12340000);
    checkOutput("bp rsp_id", 32'(rsp_id), 32'd1);

    // Illegal op still transfers and advances the pointer
    tick();
    applyStimulus(0, 1'b1, 4'b1111, 32'd1, 32'd2);
    @(negedge clk);
    checkOutput("illegal req_ready", 32'(req_ready), 32'h1);
    tick();
    applyStimulus(0, 1'b1, 4'b0010, 32'd3, 32'd4);
    applyStimulus(1, 1'b1, 4'b0010, 32'd10, 32'd20);
    @(negedge clk);
    checkOutput("illegal rsp_data", rsp_data, 32'hFFFFFFFF);
    checkOutput("illegal rsp_err", 32'(rsp_err), 32'd1);
    checkOutput("illegal ptr advanced", 32'(req_ready), 32'h2);
    tick();
    applyStimulus(1, 1'b0, 4'b0000, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("after illegal rsp_data", rsp_data, 32'd30);
    checkOutput("after illegal req_ready", 32'(req_ready), 32'h1);
    tick();
    applyStimulus(0, 1'b0, 4'b0000, 32'd0, 32'd0);
    rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("pre-reset rsp_data", rsp_data, 32'd7);

    // Reset while the response is held: dropped, pointer back to 0
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midreset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midreset rsp_data", rsp_data, 32'd0);
    tick();
    applyStimulus(0, 1'b1, 4'b0010, 32'd1, 32'd1);
    applyStimulus(1, 1'b1, 4'b0010, 32'd2, 32'd2);
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("midreset grant", 32'(req_ready), 32'h1);
`endif

    // Randomized phase; pending requests are held until accepted
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      reset = (cyc % 997 == 500);
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_valid[i] && !lastReady[i])) begin
          sel = $urandom_range(0, 5);
          case (sel)
            0: op = 4'b0000;
            1: op = 4'b0001;
            2: op = 4'b0110;
            3: op = 4'($urandom_range(0, 15));
            default: op = 4'b0010;
          endcase
          applyStimulus(i, ($urandom_range(0, 99) < 60), op, $urandom, $urandom);
          if ($urandom_range(0, 3) == 0) req_b[i*WIDTH +: WIDTH] = req_a[i*WIDTH +: WIDTH];
        end
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
    end
    tick();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
